// File: rtl/video_arb_pkg.sv
// Shared types for the video memory arbiter: grant kinds, CPU FSM states and
// the memory read latency the response pipeline is sized against.
package video_arb_pkg;

   typedef enum logic [2:0] {
      GNT_NONE,
      GNT_VGA,
      GNT_SKID,
      GNT_CPU_RD,
      GNT_CPU_WR
   } gnt_e;

   typedef enum logic [1:0] {
      CPU_IDLE,
      CPU_WAIT,
      CPU_INFLIGHT,
      CPU_ACK
   } cpu_st_e;

   localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/canal_respuesta.sv
// Response path: carries each grant's kind alongside the memory latency and
// steers the returning word to the VGA or CPU side.
module canal_respuesta
   import video_arb_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  gnt_e              i_gnt,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_vga_valid,
   output logic [DATA_W-1:0] o_vga_data,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_rdata
);

   // One stage matches the registered mem_* outputs, the rest the memory itself.
   localparam int STG = 1 + MEM_RD_LAT;

   gnt_e r_tag [STG];
   gnt_e w_tag_out;
   logic w_is_vga;

   assign w_tag_out = r_tag[STG-1];
   assign w_is_vga  = (w_tag_out == GNT_VGA) || (w_tag_out == GNT_SKID);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < STG; i++) r_tag[i] <= GNT_NONE;
         o_vga_valid <= 1'b0;
         o_vga_data  <= '0;
         o_cpu_ack   <= 1'b0;
         o_cpu_rdata <= '0;
      end else begin
         r_tag[0] <= i_gnt;
         for (int i = 1; i < STG; i++) r_tag[i] <= r_tag[i-1];
         o_vga_valid <= w_is_vga;
         o_cpu_ack   <= (w_tag_out == GNT_CPU_RD) || (w_tag_out == GNT_CPU_WR);
         if (w_is_vga) o_vga_data <= i_mem_rdata;
         // Writes acknowledge without disturbing the last read value.
         if (w_tag_out == GNT_CPU_RD) o_cpu_rdata <= i_mem_rdata;
      end
   end

endmodule

// File: rtl/arbitro_memoria_video.sv
// Single-port video memory arbiter, VGA fetch first, CPU in the gaps.
// Define ARB_STARVE_EN to add the starvation guard (wait counter + VGA skid).
module arbitro_memoria_video
   import video_arb_pkg::*;
#(
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_valid,
   output logic [DATA_W-1:0] vga_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
   end

   cpu_st_e           r_cpu_st, w_cpu_nxt;
   logic              r_infl;
   gnt_e              w_gnt, w_cpu_kind;
   logic [ADDR_W-1:0] w_addr;
   logic              w_cpu_pend, w_cpu_gnt;

   assign w_cpu_pend = (r_cpu_st == CPU_WAIT);
   assign w_cpu_kind = cpu_we ? GNT_CPU_WR : GNT_CPU_RD;
   assign w_cpu_gnt  = (w_gnt == GNT_CPU_RD) || (w_gnt == GNT_CPU_WR);

`ifdef ARB_STARVE_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0]  r_wait_cnt;
   logic              r_skid_vld;
   logic [ADDR_W-1:0] r_skid_addr;
   logic              w_steal;

   assign w_steal = w_cpu_pend && (r_wait_cnt == CNT_W'(STARVE_LIMIT)) &&
                    vga_req && !r_skid_vld;

   always_comb begin
      w_gnt  = GNT_NONE;
      w_addr = mem_addr;
      if (r_skid_vld) begin
         w_gnt  = GNT_SKID;
         w_addr = r_skid_addr;
      end else if (w_steal) begin
         w_gnt  = w_cpu_kind;
         w_addr = cpu_addr;
      end else if (vga_req) begin
         w_gnt  = GNT_VGA;
         w_addr = vga_addr;
      end else if (w_cpu_pend) begin
         w_gnt  = w_cpu_kind;
         w_addr = cpu_addr;
      end
   end

   // While the skid is being served, a new fetch replaces it, so it never overflows.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_skid_vld  <= 1'b0;
         r_skid_addr <= '0;
         r_wait_cnt  <= '0;
      end else begin
         if (r_skid_vld) begin
            r_skid_vld  <= vga_req;
            r_skid_addr <= vga_addr;
         end else if (w_steal) begin
            r_skid_vld  <= 1'b1;
            r_skid_addr <= vga_addr;
         end
         if (w_cpu_gnt)
            r_wait_cnt <= '0;
         else if (w_cpu_pend && r_wait_cnt != CNT_W'(STARVE_LIMIT))
            r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end
`else
   always_comb begin
      w_gnt  = GNT_NONE;
      w_addr = mem_addr;
      if (vga_req) begin
         w_gnt  = GNT_VGA;
         w_addr = vga_addr;
      end else if (w_cpu_pend) begin
         w_gnt  = w_cpu_kind;
         w_addr = cpu_addr;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         mem_we <= (w_gnt == GNT_CPU_WR);
         if (w_gnt != GNT_NONE) mem_addr <= w_addr;
         if (w_gnt == GNT_CPU_WR) mem_wdata <= cpu_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cpu_st <= CPU_IDLE;
         r_infl   <= 1'b0;
      end else begin
         r_cpu_st <= w_cpu_nxt;
         r_infl   <= (r_cpu_st == CPU_INFLIGHT) && !r_infl;
      end
   end

   // INFLIGHT spans two cycles so CPU_ACK lines up with the returned response.
   always_comb begin
      w_cpu_nxt = r_cpu_st;
      case (r_cpu_st)
         CPU_IDLE:     if (cpu_req) w_cpu_nxt = CPU_WAIT;
         CPU_WAIT:     if (w_cpu_gnt) w_cpu_nxt = CPU_INFLIGHT;
         CPU_INFLIGHT: if (r_infl) w_cpu_nxt = CPU_ACK;
         default:      w_cpu_nxt = CPU_IDLE;
      endcase
   end

   canal_respuesta #(.DATA_W(DATA_W)) u_canal (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_gnt       (w_gnt),
      .i_mem_rdata (mem_rdata),
      .o_vga_valid (vga_valid),
      .o_vga_data  (vga_data),
      .o_cpu_ack   (cpu_ack),
      .o_cpu_rdata (cpu_rdata)
   );

endmodule
